core_top: RTL and testbench
===========================

Name: core_top

Overview:
- Single-cycle RV32I integer core with on-chip instruction memory and data memory; top of the CPU design.
- Instruction and data memories are not reset. Benches load them by backdoor access; the core is the only design unit.
- The compliance bench monitors x3 (test number), x26 (end flag) and x27 (pass flag).

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 32-bit words, stored as 4 byte lanes.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.

Behaviour:
- Reset (rst low): PC = RESET_PC; all 32 registers = 0. The reset takes effect asynchronously and is released synchronously at the next clk edge. Memories are untouched.
- Reset asserted mid-program: state clears immediately; execution restarts at RESET_PC.
- Execution model: one instruction per cycle, no pipeline, no stalls.
  - Fetch is a combinational read of imem[PC[11:2]].
  - The next PC is registered at the clock edge.
- ISA, full RV32I:
  - LUI, AUIPC, JAL, JALR (target with bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU and SB/SH/SW.
  - OP-IMM and OP, including SLT/SLTU, shifts (shift amount [4:0]) and SRA/SRAI sign-fill.
- FENCE, ECALL, EBREAK and any undefined opcode execute as NOP (PC+4, no writes).
- Arithmetic: 32-bit modulo wrap-around; no overflow traps.
- Register file:
  - x0 reads 0 and writes to it are discarded.
  - Two combinational read ports, one write port at the clock edge.
  - A same-cycle read of the register being written returns the old value.
- Data memory:
  - Address is addr[11:2] (word index, wraps modulo DMEM_WORDS); higher address bits are ignored, so byte 0x1000 maps to word 0.
  - Reads are combinational. Writes happen at the clock edge using per-lane byte enables.
  - SB: lane addr[1:0]. SH: lanes {addr[1],0} and {addr[1],1}, with addr[0] ignored. SW: all lanes, with addr[1:0] ignored.
  - Loads select the lane(s) the same way, then sign- or zero-extend.
  - Little-endian: lane0 = bits[7:0].
- Instruction memory: imem[PC[11:2]]; no misaligned-fetch trap.
- Required backdoor hierarchy:
  - u_Registers.regfile[0:31]
  - u_InstFetch.u_InstCatch.u_ramGen.ram[0:1023] (32-bit)
  - u_MemoryAccess.u_DataCatch.u0_ramGen.ram through u3_ramGen.ram, each [0:1023] x 8-bit (u0 = bits[7:0], u3 = bits[31:24]).

Optional Feature:
- CORE_HALT_EN defined: in the cycle after x26 is written with 1, PC freezes and all register and memory writes are suppressed until reset. This holds x3, x26 and x27 stable.
- Not defined: the core keeps executing normally regardless of x26.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM).
  - funct3 constants for branches, loads/stores and ALU ops.
  - ALU-op enumeration.
  - XLEN=32.
- Natural sub-module: registers (32x32 register file, async active-low clear).
- The memories reuse one generic single-port ram_gen (parameterised width/depth) to provide the required instance paths.

Test Plan:
- Reset and first fetch:
  - Stimulus: hold rst low, then release.
  - Required: PC=0 and all regs 0 during reset; the first instruction at imem[0] retires on the first edge after release.
- Arithmetic: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SLTU x4,x1,x2; SRAI x5,x2,1 -> x3=2, x4=1, x5=0xFFFF_FFFE.
- x0 write: ADDI x0,x0,7 -> x0 still reads 0.
- Store/load lanes:
  - Stimulus: x6=0x1000; x7=0x8081_8283; SW x7,0(x6); SB x0,1(x6).
  - Then LW gives 0x8081_0083, LB from offset 0 gives 0xFFFF_FF83, LHU from offset 2 gives 0x0000_8081.
  - u1_ramGen.ram[0] = 0x00.
- Control flow:
  - BEQ taken advances PC by its offset; BNE not taken gives PC+4.
  - JAL x1,+8 from PC 0x20 gives x1=0x24, PC=0x28.
  - JALR x0,x1,1 gives PC=0x24.
- Compliance run: load an RV32I test image (words 0-1023 to imem, 1024-2047 to dmem) -> x26 becomes 1 with x27=1; on fail, x3 holds the failing test number.

Source files
------------

// File: rtl/core_top_pkg.sv
// Shared definitions for the RV32I core: opcode and funct3 encodings,
// the ALU operation set and the ALU evaluation helper.
package core_top_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Shift amounts use only b[4:0]; everything wraps modulo 2^32.
    function automatic logic [XLEN-1:0] alu_exec(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'd0, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_top_data_catch.sv
// Data storage as four byte lanes (u0 = bits[7:0] ... u3 = bits[31:24]).
// Ports: clk_i, be_i (lane write enables), addr_i (word index), wdata_i, rdata_o.
module core_top_data_catch #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    core_top_ram_gen #(.WIDTH(8), .DEPTH(DEPTH)) u0_ramGen (
        .clk_i(clk_i), .we_i(be_i[0]), .addr_i(addr_i),
        .wdata_i(wdata_i[7:0]), .rdata_o(rdata_o[7:0]));
    core_top_ram_gen #(.WIDTH(8), .DEPTH(DEPTH)) u1_ramGen (
        .clk_i(clk_i), .we_i(be_i[1]), .addr_i(addr_i),
        .wdata_i(wdata_i[15:8]), .rdata_o(rdata_o[15:8]));
    core_top_ram_gen #(.WIDTH(8), .DEPTH(DEPTH)) u2_ramGen (
        .clk_i(clk_i), .we_i(be_i[2]), .addr_i(addr_i),
        .wdata_i(wdata_i[23:16]), .rdata_o(rdata_o[23:16]));
    core_top_ram_gen #(.WIDTH(8), .DEPTH(DEPTH)) u3_ramGen (
        .clk_i(clk_i), .we_i(be_i[3]), .addr_i(addr_i),
        .wdata_i(wdata_i[31:24]), .rdata_o(rdata_o[31:24]));
endmodule

// File: rtl/core_top_inst_catch.sv
// Instruction storage: a read-only word RAM addressed by word index.
// Ports: clk_i, addr_i (word index), instr_o (combinational).
module core_top_inst_catch #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [31:0]              instr_o
);
    core_top_ram_gen #(.WIDTH(32), .DEPTH(DEPTH)) u_ramGen (
        .clk_i  (clk_i),
        .we_i   (1'b0),
        .addr_i (addr_i),
        .wdata_i(32'd0),
        .rdata_o(instr_o)
    );
endmodule

// File: rtl/core_top_inst_fetch.sv
// Fetch stage: combinational instruction read at the current PC word index.
// Ports: clk_i, addr_i (PC word index), instr_o.
module core_top_inst_fetch #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [31:0]              instr_o
);
    core_top_inst_catch #(.DEPTH(DEPTH)) u_InstCatch (
        .clk_i  (clk_i),
        .addr_i (addr_i),
        .instr_o(instr_o)
    );
endmodule

// File: rtl/core_top_mem_access.sv
// Load/store unit: steers store data onto byte lanes and extracts/extends
// load data. Ports: clk_i, we_i (store), funct3_i, addr_i (byte address,
// low bits only), wdata_i (rs2), rdata_o (extended load result).
module core_top_mem_access
    import core_top_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [2:0]                 funct3_i,
    input  logic [$clog2(DEPTH)+1:0]   addr_i,
    input  logic [XLEN-1:0]            wdata_i,
    output logic [XLEN-1:0]            rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  lane_s;
    logic [3:0]  be_s;
    logic [31:0] lane_wdata_s;
    logic [31:0] word_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign lane_s = addr_i[1:0];

    // Store lane enables and replicated write data
    always_comb begin
        be_s         = 4'b0000;
        lane_wdata_s = wdata_i;
        case (funct3_i)
            F3_SB: begin
                be_s         = 4'b0001 << lane_s;
                lane_wdata_s = {4{wdata_i[7:0]}};
            end
            F3_SH: begin
                be_s         = lane_s[1] ? 4'b1100 : 4'b0011;
                lane_wdata_s = {2{wdata_i[15:0]}};
            end
            F3_SW:   be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
    end

    core_top_data_catch #(.DEPTH(DEPTH)) u_DataCatch (
        .clk_i  (clk_i),
        .be_i   (be_s & {4{we_i}}),
        .addr_i (addr_i[AW+1:2]),
        .wdata_i(lane_wdata_s),
        .rdata_o(word_s)
    );

    // Byte lane select for loads
    always_comb begin
        case (lane_s)
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = word_s[7:0];
        endcase
    end

    assign half_s = lane_s[1] ? word_s[31:16] : word_s[15:0];

    // Load extension
    always_comb begin
        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   rdata_o = {{16{half_s[15]}}, half_s};
            F3_LW:   rdata_o = word_s;
            F3_LBU:  rdata_o = {24'd0, byte_s};
            F3_LHU:  rdata_o = {16'd0, half_s};
            default: rdata_o = word_s;
        endcase
    end
endmodule

// File: rtl/core_top_ram_gen.sv
// Generic single-port RAM: combinational read, write on the rising edge.
// Contents are never reset. Ports: clk_i, we_i, addr_i, wdata_i, rdata_o.
module core_top_ram_gen #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] ram [0:DEPTH-1];

    // Storage write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            ram[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = ram[addr_i];
endmodule

// File: rtl/core_top_regs.sv
// 32 x 32 register file: two combinational read ports, one write port.
// x0 always reads zero. A read of the register being written this cycle
// returns the old value. Async active-low clear.
// Ports: clk_i, rst_ni, rs1/rs2 address and data, we_i, rd_addr_i, rd_data_i.
module core_top_regs
    import core_top_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            we_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i
);
    logic [XLEN-1:0] regfile [0:31];

    // Register write; x0 is never written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= {XLEN{1'b0}};
            end
        end else if (we_i && (rd_addr_i != 5'd0)) begin
            regfile[rd_addr_i] <= rd_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == 5'd0) ? {XLEN{1'b0}} : regfile[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? {XLEN{1'b0}} : regfile[rs2_addr_i];
endmodule

// File: rtl/core_top.sv
// Single-cycle RV32I core with on-chip instruction and data memories.
// Ports: clk (rising-edge clock), rst (asynchronous, active-low reset).
// Optional macro CORE_HALT_EN: once x26 is written with 1, the following
// cycles freeze the PC and suppress all register and memory writes.
module core_top
    import core_top_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4_s, next_pc_s, instr_s;
    logic [6:0]      opcode_s;
    logic [4:0]      rd_s, rs1_s, rs2_s;
    logic [2:0]      f3_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [XLEN-1:0] rs1_data_s, rs2_data_s, alu_res_s, agu_s, load_data_s, wb_data_s;
    alu_op_e         alu_op_s;
    logic            br_cond_s, rf_we_s, mem_we_s, halt_s;
    logic            unused_agu_s;

    core_top_inst_fetch #(.DEPTH(IMEM_WORDS)) u_InstFetch (
        .clk_i  (clk),
        .addr_i (pc_q[IAW+1:2]),
        .instr_o(instr_s)
    );

    assign opcode_s = instr_s[6:0];
    assign rd_s     = instr_s[11:7];
    assign f3_s     = instr_s[14:12];
    assign rs1_s    = instr_s[19:15];
    assign rs2_s    = instr_s[24:20];
    assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s  = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_u_s  = {instr_s[31:12], 12'd0};
    assign imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

    core_top_regs u_Registers (
        .clk_i     (clk),
        .rst_ni    (rst),
        .rs1_addr_i(rs1_s),
        .rs2_addr_i(rs2_s),
        .rs1_data_o(rs1_data_s),
        .rs2_data_o(rs2_data_s),
        .we_i      (rf_we_s & ~halt_s),
        .rd_addr_i (rd_s),
        .rd_data_i (wb_data_s)
    );

    // ALU operation decode; SUB exists only in register-register form
    always_comb begin
        case (f3_s)
            F3_ADD:  alu_op_s = ((opcode_s == OP_REG) && instr_s[30]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op_s = ALU_SLL;
            F3_SLT:  alu_op_s = ALU_SLT;
            F3_SLTU: alu_op_s = ALU_SLTU;
            F3_XOR:  alu_op_s = ALU_XOR;
            F3_SR:   alu_op_s = instr_s[30] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op_s = ALU_OR;
            F3_AND:  alu_op_s = ALU_AND;
            default: alu_op_s = ALU_ADD;
        endcase
    end

    assign alu_res_s  = alu_exec(alu_op_s, rs1_data_s, (opcode_s == OP_REG) ? rs2_data_s : imm_i_s);
    assign agu_s      = rs1_data_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
    assign pc_plus4_s = pc_q + 32'd4;

    // Upper data-address bits are ignored: the word index wraps.
    assign unused_agu_s = ^agu_s[XLEN-1:DAW+2];

    core_top_mem_access #(.DEPTH(DMEM_WORDS)) u_MemoryAccess (
        .clk_i   (clk),
        .we_i    (mem_we_s & ~halt_s),
        .funct3_i(f3_s),
        .addr_i  (agu_s[DAW+1:0]),
        .wdata_i (rs2_data_s),
        .rdata_o (load_data_s)
    );

    // Branch condition evaluation
    always_comb begin
        case (f3_s)
            F3_BEQ:  br_cond_s = (rs1_data_s == rs2_data_s);
            F3_BNE:  br_cond_s = (rs1_data_s != rs2_data_s);
            F3_BLT:  br_cond_s = ($signed(rs1_data_s) < $signed(rs2_data_s));
            F3_BGE:  br_cond_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
            F3_BLTU: br_cond_s = (rs1_data_s < rs2_data_s);
            F3_BGEU: br_cond_s = (rs1_data_s >= rs2_data_s);
            default: br_cond_s = 1'b0;
        endcase
    end

    // Main control: writeback selection, store enable and next PC.
    // FENCE, SYSTEM and unknown opcodes fall through as NOPs.
    always_comb begin
        next_pc_s = pc_plus4_s;
        rf_we_s   = 1'b0;
        mem_we_s  = 1'b0;
        wb_data_s = alu_res_s;
        case (opcode_s)
            OP_LUI:    begin rf_we_s = 1'b1; wb_data_s = imm_u_s; end
            OP_AUIPC:  begin rf_we_s = 1'b1; wb_data_s = pc_q + imm_u_s; end
            OP_JAL: begin
                rf_we_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                next_pc_s = pc_q + imm_j_s;
            end
            OP_JALR: begin
                rf_we_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                next_pc_s = (rs1_data_s + imm_i_s) & ~32'd1;
            end
            OP_BRANCH: next_pc_s = br_cond_s ? (pc_q + imm_b_s) : pc_plus4_s;
            OP_LOAD:   begin rf_we_s = 1'b1; wb_data_s = load_data_s; end
            OP_STORE:  mem_we_s = 1'b1;
            OP_IMM:    rf_we_s = 1'b1;
            OP_REG:    rf_we_s = 1'b1;
            OP_FENCE:  next_pc_s = pc_plus4_s;
            OP_SYSTEM: next_pc_s = pc_plus4_s;
            default:   next_pc_s = pc_plus4_s;
        endcase
    end

`ifdef CORE_HALT_EN
    logic halt_q;

    // Sticky halt once x26 receives the value 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q <= 1'b0;
        end else if (rf_we_s && !halt_q && (rd_s == 5'd26) && (wb_data_s == 32'd1)) begin
            halt_q <= 1'b1;
        end
    end

    assign halt_s = halt_q;
`else
    assign halt_s = 1'b0;
`endif

    assign pc_d = halt_s ? pc_q : next_pc_s;

    // Program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: tb/tb_core_top.sv
module tb_core_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    core_top dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic set_imem(input int idx, input logic [31:0] w);
        dut.u_InstFetch.u_InstCatch.u_ramGen.ram[idx] = w;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty: observed %h required none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                tests_failed++;
                $error("FAIL %s: observed %h required %h", t, obs, e);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nz;

        // Program 1: arithmetic, x0, store/load lanes, branches
        for (int i = 0; i < 1024; i++) set_imem(i, 32'h0000_0013);
        set_imem(0,  enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011));   // ADDI x1,x0,5
        set_imem(1,  enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011));   // ADDI x2,x0,-3
        set_imem(2,  enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3));            // ADD x3,x1,x2
        set_imem(3,  enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd4));            // SLTU x4,x1,x2
        set_imem(4,  enc_i({7'b0100000, 5'd1}, 5'd2, 3'b101, 5'd5, 7'b0010011)); // SRAI x5,x2,1
        set_imem(5,  enc_i(12'd7,   5'd0, 3'b000, 5'd0, 7'b0010011));   // ADDI x0,x0,7
        set_imem(6,  enc_u(20'h00001, 5'd6, 7'b0110111));               // LUI x6,0x1
        set_imem(7,  enc_u(20'h80818, 5'd7, 7'b0110111));               // LUI x7,0x80818
        set_imem(8,  enc_i(12'h283, 5'd7, 3'b000, 5'd7, 7'b0010011));   // ADDI x7,x7,0x283
        set_imem(9,  enc_s(12'd0, 5'd7, 5'd6, 3'b010));                 // SW x7,0(x6)
        set_imem(10, enc_s(12'd1, 5'd0, 5'd6, 3'b000));                 // SB x0,1(x6)
        set_imem(11, enc_i(12'd0, 5'd6, 3'b010, 5'd8,  7'b0000011));    // LW x8,0(x6)
        set_imem(12, enc_i(12'd0, 5'd6, 3'b000, 5'd9,  7'b0000011));    // LB x9,0(x6)
        set_imem(13, enc_i(12'd2, 5'd6, 3'b101, 5'd10, 7'b0000011));    // LHU x10,2(x6)
        set_imem(14, enc_b(13'd8, 5'd0, 5'd0, 3'b000));                 // BEQ x0,x0,+8
        set_imem(15, enc_i(12'd1, 5'd0, 3'b000, 5'd11, 7'b0010011));    // ADDI x11 (skipped)
        set_imem(16, enc_b(13'd8, 5'd0, 5'd0, 3'b001));                 // BNE x0,x0,+8
        set_imem(17, enc_i(12'd2, 5'd0, 3'b000, 5'd12, 7'b0010011));    // ADDI x12,x0,2
        set_imem(18, enc_j(21'd0, 5'd0));                               // JAL x0,0 (spin)

        #2 rst = 1'b0;
        #1;
        expect_val("reset_pc", 32'h0);
        expect_val("reset_regs_nonzero", 32'd0);
        check_next(dut.pc_q);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.u_Registers.regfile[i] !== 32'd0) nz++;
        check_next(32'(nz));

        @(negedge clk);
        rst = 1'b1;
        expect_val("first_pc", 32'h4);
        expect_val("first_x1", 32'd5);
        run(1);
        check_next(dut.pc_q);
        check_next(dut.u_Registers.regfile[1]);

        expect_val("addi_neg_x2", 32'hFFFF_FFFD);
        expect_val("add_x3", 32'd2);
        expect_val("sltu_x4", 32'd1);
        expect_val("srai_x5", 32'hFFFF_FFFE);
        run(4);
        check_next(dut.u_Registers.regfile[2]);
        check_next(dut.u_Registers.regfile[3]);
        check_next(dut.u_Registers.regfile[4]);
        check_next(dut.u_Registers.regfile[5]);

        expect_val("x0_zero", 32'd0);
        run(1);
        check_next(dut.u_Registers.regfile[0]);

        expect_val("lui_x6", 32'h0000_1000);
        expect_val("x7", 32'h8081_8283);
        expect_val("lw_x8", 32'h8081_0083);
        expect_val("lb_x9", 32'hFFFF_FF83);
        expect_val("lhu_x10", 32'h0000_8081);
        expect_val("lane1_ram0", 32'h0000_0000);
        expect_val("lane3_ram0", 32'h0000_0080);
        expect_val("pc_before_beq", 32'h38);
        run(8);
        check_next(dut.u_Registers.regfile[6]);
        check_next(dut.u_Registers.regfile[7]);
        check_next(dut.u_Registers.regfile[8]);
        check_next(dut.u_Registers.regfile[9]);
        check_next(dut.u_Registers.regfile[10]);
        check_next({24'd0, dut.u_MemoryAccess.u_DataCatch.u1_ramGen.ram[0]});
        check_next({24'd0, dut.u_MemoryAccess.u_DataCatch.u3_ramGen.ram[0]});
        check_next(dut.pc_q);

        expect_val("beq_taken_pc", 32'h40);
        run(1);
        check_next(dut.pc_q);
        expect_val("bne_not_taken_pc", 32'h44);
        run(1);
        check_next(dut.pc_q);
        expect_val("x12_after_bne", 32'd2);
        expect_val("x11_skipped", 32'd0);
        expect_val("spin_pc", 32'h48);
        run(4);
        check_next(dut.u_Registers.regfile[12]);
        check_next(dut.u_Registers.regfile[11]);
        check_next(dut.pc_q);

        // Reset mid-program: takes effect without a clock edge
        rst = 1'b0;
        #1;
        expect_val("midreset_pc", 32'h0);
        expect_val("midreset_x1", 32'd0);
        expect_val("midreset_x12", 32'd0);
        check_next(dut.pc_q);
        check_next(dut.u_Registers.regfile[1]);
        check_next(dut.u_Registers.regfile[12]);

        // Program 2: jumps
        for (int i = 0; i < 8; i++) set_imem(i, enc_i(12'd1, 5'd13, 3'b000, 5'd13, 7'b0010011));
        set_imem(8,  enc_j(21'd8, 5'd1));                                // JAL x1,+8 at 0x20
        set_imem(9,  enc_i(12'd1, 5'd14, 3'b000, 5'd14, 7'b0010011));   // ADDI x14,x14,1
        set_imem(10, enc_i(12'd1, 5'd1, 3'b000, 5'd0, 7'b1100111));     // JALR x0,x1,1

        @(negedge clk);
        rst = 1'b1;
        expect_val("restart_x13", 32'd8);
        expect_val("restart_pc", 32'h20);
        run(8);
        check_next(dut.u_Registers.regfile[13]);
        check_next(dut.pc_q);

        expect_val("jal_link_x1", 32'h24);
        expect_val("jal_pc", 32'h28);
        run(1);
        check_next(dut.u_Registers.regfile[1]);
        check_next(dut.pc_q);

        expect_val("jalr_pc", 32'h24);
        run(1);
        check_next(dut.pc_q);

        expect_val("x14_after_jalr", 32'd1);
        expect_val("loop_pc", 32'h28);
        expect_val("dmem_kept_lane0", 32'h0000_0083);
        run(1);
        check_next(dut.u_Registers.regfile[14]);
        check_next(dut.pc_q);
        check_next({24'd0, dut.u_MemoryAccess.u_DataCatch.u0_ramGen.ram[0]});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
